// File: rtl/id_ex_hazard_ctrl.sv
// rtl/id_ex_hazard_ctrl.sv - ID/EX hazard control: forwarding, load-use/divide stalls, redirect flushes
module id_ex_hazard_ctrl #(
  parameter int XLEN        = 64,
  parameter int DIV_TIMEOUT = 80
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_is_store,
  input  logic [4:0]      ex_wR,
  input  logic            ex_rf_we,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      mem_wR,
  input  logic            mem_rf_we,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [4:0]      wb_wR,
  input  logic            wb_rf_we,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            ex_div_start,
  input  logic            div_done,
  input  logic            ex_redirect,
  output logic            forward_A_sig,
  output logic            forward_B_sig,
  output logic [XLEN-1:0] forward_A,
  output logic [XLEN-1:0] forward_B,
  output logic            stall_pc,
  output logic            stall_if_id,
  output logic            hold_id_ex,
  output logic            flush_if_id,
  output logic            flush,
  output logic            div_err,
  output logic [31:0]     stall_cnt
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_STALL, S_DIV_BUSY} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_div_cnt;
  logic           r_div_err;
  logic [31:0]    r_stall_cnt;

  logic w_a_ok, w_b_ok;
  logic w_a_ex, w_a_mem, w_a_wb;
  logic w_b_ex, w_b_mem, w_b_wb;
  logic w_load_use;
  logic w_stall, w_hold, w_flush_if_id, w_flush;
  logic w_unused;

  // Stores still get forward_B_sig; the ID/EX register does the masking.
  assign w_unused = id_is_store;

  assign w_a_ok  = id_use_rs1 && (id_rs1 != 5'd0);
  assign w_b_ok  = id_use_rs2 && (id_rs2 != 5'd0);
  assign w_a_ex  = w_a_ok && ex_rf_we && !ex_is_load && (ex_wR == id_rs1);
  assign w_a_mem = w_a_ok && mem_rf_we && (mem_wR == id_rs1);
  assign w_a_wb  = w_a_ok && wb_rf_we && (wb_wR == id_rs1);
  assign w_b_ex  = w_b_ok && ex_rf_we && !ex_is_load && (ex_wR == id_rs2);
  assign w_b_mem = w_b_ok && mem_rf_we && (mem_wR == id_rs2);
  assign w_b_wb  = w_b_ok && wb_rf_we && (wb_wR == id_rs2);

  assign w_load_use = ex_is_load && ex_rf_we && (ex_wR != 5'd0) &&
                      ((id_use_rs1 && (ex_wR == id_rs1)) ||
                       (id_use_rs2 && (ex_wR == id_rs2)));

  always_comb begin
    forward_A_sig = 1'b0;
    forward_A     = '0;
    forward_B_sig = 1'b0;
    forward_B     = '0;
    if (reset) begin
      if (w_a_ex) begin
        forward_A_sig = 1'b1;
        forward_A     = ex_result;
      end else if (w_a_mem) begin
        forward_A_sig = 1'b1;
        forward_A     = mem_wdata;
      end else if (w_a_wb) begin
        forward_A_sig = 1'b1;
        forward_A     = wb_wdata;
      end
      if (w_b_ex) begin
        forward_B_sig = 1'b1;
        forward_B     = ex_result;
      end else if (w_b_mem) begin
        forward_B_sig = 1'b1;
        forward_B     = mem_wdata;
      end else if (w_b_wb) begin
        forward_B_sig = 1'b1;
        forward_B     = wb_wdata;
      end
    end
  end

  // Controls act in the cycle the hazard is seen, so they decode state and inputs directly.
  always_comb begin
    w_stall       = 1'b0;
    w_hold        = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush       = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          if (!ex_div_start) begin
            if (ex_redirect) begin
              w_flush_if_id = 1'b1;
              w_flush       = 1'b1;
            end else if (w_load_use) begin
              w_stall = 1'b1;
              w_flush = 1'b1;
            end
          end
        end
        S_LOAD_STALL: begin
          if (ex_redirect) begin
            w_flush_if_id = 1'b1;
            w_flush       = 1'b1;
          end
        end
        S_DIV_BUSY: begin
          if (!div_done) begin
            w_stall = 1'b1;
            w_hold  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_div_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (ex_div_start) begin
            r_state   <= S_DIV_BUSY;
            r_div_cnt <= '0;
          end else if (!ex_redirect && w_load_use) begin
            r_state <= S_LOAD_STALL;
          end
        end
        S_LOAD_STALL: r_state <= S_IDLE;
        S_DIV_BUSY: begin
          if (div_done) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
          end else if (r_div_cnt == CW'(DIV_TIMEOUT - 1)) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_div_err <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_pc    = w_stall;
  assign stall_if_id = w_stall;
  assign hold_id_ex  = w_hold;
  assign flush_if_id = w_flush_if_id;
  assign flush       = w_flush;
  assign div_err     = r_div_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb/tb_id_ex_hazard_ctrl.sv - directed bench for id_ex_hazard_ctrl
module tb_id_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
  logic        id_use_rs1, id_use_rs2, id_is_store;
  logic        ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
  logic [63:0] ex_result, mem_wdata, wb_wdata;
  logic        ex_div_start, div_done, ex_redirect;
  logic        forward_A_sig, forward_B_sig;
  logic [63:0] forward_A, forward_B;
  logic        stall_pc, stall_if_id, hold_id_ex, flush_if_id, flush, div_err;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl #(.XLEN(64), .DIV_TIMEOUT(80)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_store(id_is_store),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_wdata(mem_wdata),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .wb_wdata(wb_wdata),
    .ex_div_start(ex_div_start), .div_done(div_done), .ex_redirect(ex_redirect),
    .forward_A_sig(forward_A_sig), .forward_B_sig(forward_B_sig),
    .forward_A(forward_A), .forward_B(forward_B),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .hold_id_ex(hold_id_ex),
    .flush_if_id(flush_if_id), .flush(flush), .div_err(div_err), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0]  rs1;  logic u1;
    logic [4:0]  rs2;  logic u2;
    logic [4:0]  exw;  logic exwe; logic exld;
    logic [4:0]  memw; logic memwe;
    logic [4:0]  wbw;  logic wbwe;
    logic        ea_sig; logic [63:0] ea;
    logic        eb_sig; logic [63:0] eb;
  } fvec_t;

  fvec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_store = 0;
    ex_wR = 0; ex_rf_we = 0; ex_is_load = 0; ex_result = 64'h11;
    mem_wR = 0; mem_rf_we = 0; mem_wdata = 64'h22;
    wb_wR = 0; wb_rf_we = 0; wb_wdata = 64'h33;
    ex_div_start = 0; div_done = 0; ex_redirect = 0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic apply_vec(input fvec_t v);
    id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
    ex_wR = v.exw; ex_rf_we = v.exwe; ex_is_load = v.exld;
    mem_wR = v.memw; mem_rf_we = v.memwe; wb_wR = v.wbw; wb_rf_we = v.wbwe;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stall, n_bad;
    logic early_err;
    // rs1 u1 rs2 u2 exw exwe exld memw memwe wbw wbwe | a_sig a b_sig b
    vecs[0]  = '{5, 1, 0, 0, 5, 1, 0, 5, 1, 5, 1, 1, 64'h11, 0, 64'h0};
    vecs[1]  = '{5, 1, 0, 0, 5, 0, 0, 5, 1, 5, 1, 1, 64'h22, 0, 64'h0};
    vecs[2]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 64'h0,  0, 64'h0};
    vecs[3]  = '{5, 0, 0, 0, 5, 1, 0, 5, 1, 5, 1, 0, 64'h0,  0, 64'h0};
    vecs[4]  = '{5, 1, 0, 0, 5, 1, 1, 5, 1, 5, 1, 1, 64'h22, 0, 64'h0};
    vecs[5]  = '{5, 1, 0, 0, 3, 1, 0, 4, 1, 5, 1, 1, 64'h33, 0, 64'h0};
    vecs[6]  = '{5, 1, 0, 0, 3, 1, 0, 5, 0, 5, 1, 1, 64'h33, 0, 64'h0};
    vecs[7]  = '{9, 1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 1, 64'h11, 1, 64'h11};
    vecs[8]  = '{1, 1, 2, 1, 3, 1, 0, 3, 1, 3, 1, 0, 64'h0,  0, 64'h0};
    vecs[9]  = '{0, 0, 5, 1, 5, 1, 1, 5, 1, 0, 0, 0, 64'h0,  1, 64'h22};
    vecs[10] = '{5, 1, 6, 1, 0, 0, 0, 6, 1, 5, 0, 0, 64'h0,  1, 64'h22};
    vecs[11] = '{8, 1, 8, 0, 8, 0, 0, 8, 0, 8, 1, 1, 64'h33, 0, 64'h0};

    // Reset held with forwarding and redirect inputs active: everything must be 0
    clear_inputs();
    reset = 1'b0;
    apply_vec(vecs[0]);
    ex_redirect = 1'b1;
    #12;
    chk("rst_fwdA_sig", forward_A_sig, 0);
    chk("rst_fwdA", forward_A, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_if_id", flush_if_id, 0);
    chk("rst_stall_pc", stall_pc, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_div_err", div_err, 0);
    reset = 1'b1;
    clear_inputs();
    tick();

    // Forwarding table
    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i]);
      id_is_store = (i == 9);
      #1;
      chk($sformatf("v%0d_a_sig", i), forward_A_sig, vecs[i].ea_sig);
      chk($sformatf("v%0d_a", i), forward_A, vecs[i].ea);
      chk($sformatf("v%0d_b_sig", i), forward_B_sig, vecs[i].eb_sig);
      chk($sformatf("v%0d_b", i), forward_B, vecs[i].eb);
      tick();
    end

    // Load-use stall, then MEM forwarding in LOAD_STALL
    do_reset();
    ex_is_load = 1; ex_rf_we = 1; ex_wR = 7; id_rs2 = 7; id_use_rs2 = 1;
    #1;
    chk("lu_stall_pc", stall_pc, 1);
    chk("lu_stall_if_id", stall_if_id, 1);
    chk("lu_flush", flush, 1);
    chk("lu_hold", hold_id_ex, 0);
    chk("lu_flush_if_id", flush_if_id, 0);
    tick();
    chk("ls_stall_pc", stall_pc, 0);
    chk("ls_flush", flush, 0);
    chk("ls_stall_cnt", stall_cnt, 1);
    ex_is_load = 0; ex_rf_we = 0; mem_wR = 7; mem_rf_we = 1; mem_wdata = 64'hABC;
    #1;
    chk("ls_fwdB_sig", forward_B_sig, 1);
    chk("ls_fwdB", forward_B, 64'hABC);
    tick();
    chk("ls_back_cnt", stall_cnt, 1);

    // Divide: 33 busy cycles then div_done; redirect during busy is ignored
    do_reset();
    ex_div_start = 1;
    #1;
    chk("div_start_stall", stall_pc, 0);
    tick();
    ex_div_start = 0;
    n_stall = 0; n_bad = 0;
    for (int c = 0; c < 33; c++) begin
      ex_redirect = (c == 10);
      #1;
      if (stall_pc && stall_if_id && hold_id_ex) n_stall++;
      if (flush || flush_if_id) n_bad++;
      tick();
    end
    ex_redirect = 0;
    div_done = 1;
    #1;
    chk("div_done_stall", stall_pc, 0);
    chk("div_done_hold", hold_id_ex, 0);
    tick();
    div_done = 0;
    chk("div_stall_cycles", n_stall, 33);
    chk("div_no_flush", n_bad, 0);
    chk("div_stall_cnt", stall_cnt, 33);
    chk("div_err_clear", div_err, 0);
    ex_redirect = 1;
    #1;
    chk("div_idle_redirect", flush, 1);
    ex_redirect = 0;

    // Divide timeout
    do_reset();
    ex_div_start = 1;
    tick();
    ex_div_start = 0;
    n_stall = 0; early_err = 0;
    for (int c = 0; c < 200; c++) begin
      if (!stall_pc) break;
      if (div_err) early_err = 1;
      n_stall++;
      tick();
    end
    chk("to_stall_cycles", n_stall, 80);
    chk("to_early_err", early_err, 0);
    chk("to_div_err", div_err, 1);
    chk("to_stall_cnt", stall_cnt, 80);
    tick();
    chk("to_idle_stall", stall_pc, 0);
    chk("to_sticky", div_err, 1);

    // Redirect beats load-use; no LOAD_STALL entry
    do_reset();
    ex_is_load = 1; ex_rf_we = 1; ex_wR = 7; id_rs1 = 7; id_use_rs1 = 1; ex_redirect = 1;
    #1;
    chk("rd_flush_if_id", flush_if_id, 1);
    chk("rd_flush", flush, 1);
    chk("rd_stall_pc", stall_pc, 0);
    tick();
    ex_redirect = 0;
    #1;
    chk("rd_still_idle", stall_pc, 1);
    tick();
    clear_inputs();

    // div_start beats redirect
    do_reset();
    ex_div_start = 1; ex_redirect = 1;
    #1;
    chk("ds_rd_flush", flush, 0);
    tick();
    ex_div_start = 0; ex_redirect = 0;
    #1;
    chk("ds_rd_busy", hold_id_ex, 1);

    // Async reset in the middle of DIV_BUSY
    tick();
    apply_vec(vecs[0]);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_stall_pc", stall_pc, 0);
    chk("ar_stall_if_id", stall_if_id, 0);
    chk("ar_hold", hold_id_ex, 0);
    chk("ar_fwdA_sig", forward_A_sig, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    #3;
    reset = 1'b1;
    clear_inputs();
    tick();
    chk("ar_post_idle", stall_pc, 0);
    chk("ar_post_hold", hold_id_ex, 0);
    chk("ar_post_cnt", stall_cnt, 0);
    chk("ar_post_err", div_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
